// File: rtl/amux_pkg.sv
// Shared types and default timing for the multiplexed async memory bus initiator.
// Phase lengths are in clk cycles; the phase counter holds (length - 1).
package amux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    AHOLD,
    DATA,
    TURN
  } amux_state_t;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } amux_req_t;

  localparam int unsigned DEF_ADDSET  = 3;
  localparam int unsigned DEF_ADDHLD  = 1;
  localparam int unsigned DEF_DATAST  = 4;
  localparam int unsigned DEF_BUSTURN = 2;

  function automatic logic [3:0] phase_load(input int unsigned n);
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic aclr,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!aclr) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mcu_amux_master.sv
// Initiator for the multiplexed async memory bus (mode-D timing), single-beat requests.
// state | meaning:  IDLE ready | ADDR nadv low, addr on ad | AHOLD addr held | DATA strobe low | TURN bus released
module mcu_amux_master
  import amux_pkg::*;
#(
  parameter int unsigned ADDSET  = DEF_ADDSET,
  parameter int unsigned ADDHLD  = DEF_ADDHLD,
  parameter int unsigned DATAST  = DEF_DATAST,
  parameter int unsigned BUSTURN = DEF_BUSTURN
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        ne,
  output logic        noe,
  output logic        nwe,
  output logic        nadv,
  output logic [1:0]  nbl,
  inout  wire  [15:0] ad,
  input  logic        nirq,
  output logic        irq
);

  amux_state_t r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  amux_req_t   r_req, w_req_nxt;

  logic        r_ready;
  logic        r_ne, r_noe, r_nwe, r_nadv;
  logic [1:0]  r_nbl;
  logic        r_ad_oe;
  logic [15:0] r_ad_out;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;

  logic        w_accept;
  logic        w_bus_nxt;
  logic        w_rd_done;
  logic        w_nirq_sync;

  assign w_accept  = req_valid & r_ready;
  assign w_rd_done = (r_state == DATA) && (r_cnt == 4'd0) && !r_req.write;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = ADDR;
          w_cnt_nxt   = phase_load(ADDSET);
          w_req_nxt   = '{write: req_write, addr: req_addr, be: req_be, wdata: req_wdata};
        end
      end
      ADDR: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else if (ADDHLD == 0) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = phase_load(DATAST);
        end else begin
          w_state_nxt = AHOLD;
          w_cnt_nxt   = phase_load(ADDHLD);
        end
      end
      AHOLD: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = DATA;
          w_cnt_nxt   = phase_load(DATAST);
        end
      end
      DATA: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = TURN;
          w_cnt_nxt   = phase_load(BUSTURN);
        end
      end
      TURN: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_bus_nxt = w_state_nxt inside {ADDR, AHOLD, DATA};

  // Strobes and the ad driver are decoded from the next state so they change on the clock edge only.
  always_ff @(posedge clk) begin
    if (!aclr) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_req       <= '0;
      r_ready     <= 1'b0;
      r_ne        <= 1'b1;
      r_noe       <= 1'b1;
      r_nwe       <= 1'b1;
      r_nadv      <= 1'b1;
      r_nbl       <= 2'b11;
      r_ad_oe     <= 1'b0;
      r_ad_out    <= 16'h0000;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req       <= w_req_nxt;
      r_ready     <= (w_state_nxt == IDLE);
      r_ne        <= !w_bus_nxt;
      r_nadv      <= !(w_state_nxt == ADDR);
      r_nwe       <= !((w_state_nxt == DATA) && w_req_nxt.write);
      r_noe       <= !((w_state_nxt == DATA) && !w_req_nxt.write);
      r_nbl       <= w_bus_nxt ? ~w_req_nxt.be : 2'b11;
      r_ad_oe     <= (w_state_nxt inside {ADDR, AHOLD}) ||
                     ((w_state_nxt == DATA) && w_req_nxt.write);
      r_ad_out    <= (w_state_nxt == DATA) ? w_req_nxt.wdata : w_req_nxt.addr;
      r_rsp_valid <= w_rd_done;
      if (w_rd_done) begin
        r_rsp_rdata <= ad;
      end
    end
  end

  assign ad        = r_ad_oe ? r_ad_out : 16'hzzzz;
  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign ne        = r_ne;
  assign noe       = r_noe;
  assign nwe       = r_nwe;
  assign nadv      = r_nadv;
  assign nbl       = r_nbl;

  // Reset value 1 keeps irq low out of reset.
  sync_2ff #(.RST_VAL(1'b1)) u_sync_nirq (
    .clk  (clk),
    .aclr (aclr),
    .i_d  (nirq),
    .o_q  (w_nirq_sync)
  );

  assign irq = ~w_nirq_sync;

endmodule

// File: tb/tb_mcu_amux_master.sv
// Scoreboard bench: driver queues expected bus cycles and read responses, monitors pop and compare.
module tb_mcu_amux_master;
  import amux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aclr;
  logic        req_valid, req_write, req_ready, rsp_valid;
  logic [15:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_be, nbl;
  logic        ne, noe, nwe, nadv, nirq, irq;
  wire  [15:0] ad;

  logic        h_valid, h_ready, h_rsp_valid, h_ne, h_noe, h_nwe, h_nadv, h_irq;
  logic        h_write, h_nirq;
  logic [15:0] h_addr, h_wdata, h_rdata;
  logic [1:0]  h_be, h_nbl;
  wire  [15:0] h_ad;

  mcu_amux_master dut (
    .clk(clk), .aclr(aclr), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ne(ne), .noe(noe), .nwe(nwe),
    .nadv(nadv), .nbl(nbl), .ad(ad), .nirq(nirq), .irq(irq)
  );

  mcu_amux_master #(.ADDHLD(0)) dut_h (
    .clk(clk), .aclr(aclr), .req_valid(h_valid), .req_ready(h_ready),
    .req_write(h_write), .req_addr(h_addr), .req_be(h_be), .req_wdata(h_wdata),
    .rsp_valid(h_rsp_valid), .rsp_rdata(h_rdata), .ne(h_ne), .noe(h_noe), .nwe(h_nwe),
    .nadv(h_nadv), .nbl(h_nbl), .ad(h_ad), .nirq(h_nirq), .irq(h_irq)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: register map addressed by the low address byte
  logic [15:0] mem [256];
  logic [15:0] rsp_a;
  assign ad = (!ne && !noe) ? mem[rsp_a[7:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ne && !nadv) rsp_a <= ad;
    if (!ne && !nwe) begin
      if (!nbl[0]) mem[rsp_a[7:0]][7:0]  <= ad[7:0];
      if (!nbl[1]) mem[rsp_a[7:0]][15:8] <= ad[15:8];
    end
  end

  typedef struct { logic write; logic [15:0] addr; logic [1:0] be; logic [15:0] data; } bus_rec_t;
  typedef struct { logic [15:0] data; int cyc; } rsp_rec_t;
  bus_rec_t exp_bus[$];
  rsp_rec_t exp_rsp[$];

  // Bus monitor: measures each ne-low window and compares it with the queued expectation
  bit          m_in = 0, m_seen = 0, m_bad;
  int          m_ne, m_nadv, m_ahold, m_data, m_gap = 0, last_gap = 0, bus_cnt = 0;
  logic        m_wr;
  logic [15:0] m_addr, m_dv;
  logic [1:0]  m_be;
  always @(negedge clk) begin
    if (!aclr) begin
      m_in = 0;
    end else if (!ne) begin
      if (!m_in) begin
        m_in = 1; m_ne = 0; m_nadv = 0; m_ahold = 0; m_data = 0; m_bad = 0; m_wr = 0;
        if (m_seen) last_gap = m_gap;
      end
      m_ne++;
      m_be = ~nbl;
      if (!nadv) begin
        m_nadv++; m_addr = ad;
      end else if (noe && nwe) begin
        m_ahold++;
        if (ad !== m_addr) m_bad = 1;
      end else begin
        m_data++; m_wr = !nwe;
        if (!nwe && m_data > 1 && ad !== m_dv) m_bad = 1;
        m_dv = ad;
      end
    end else begin
      if (m_in) begin
        m_in = 0; m_seen = 1; m_gap = 0; bus_cnt++;
        if (exp_bus.size() == 0) check("bus_unexpected", 1, 0);
        else begin
          bus_rec_t e;
          e = exp_bus.pop_front();
          check("bus_fields", {m_wr, m_addr, m_be, m_dv}, {e.write, e.addr, e.be, e.data});
          check("bus_timing", {8'(m_nadv), 8'(m_ahold), 8'(m_data), 8'(m_ne)},
                {8'd3, 8'd1, 8'd4, 8'd8});
          check("bus_ad_stable", m_bad, 0);
        end
      end
      m_gap++;
    end
  end

  // Response monitor
  int rsp_cnt = 0;
  always @(negedge clk) begin
    if (aclr && rsp_valid) begin
      rsp_cnt++;
      if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        rsp_rec_t r;
        r = exp_rsp.pop_front();
        check("rsp_rdata", rsp_rdata, r.data);
        check("rsp_latency", cyc, r.cyc);
      end
    end
  end

  int contention = 0;
  always @(negedge clk) if (!noe && dut.r_ad_oe) contention++;

  // ADDHLD=0 instance monitor over its first cycle
  bit h_win = 0;
  int hn_adv = 0, hn_hold = 0, hn_we = 0, hn_ne = 0, hn_bad = 0;
  always @(negedge clk) begin
    if (aclr && h_win) begin
      if (!h_ne && !h_nadv) hn_adv++;
      if (!h_ne && h_nadv && h_nwe && h_noe) hn_hold++;
      if (!h_nwe) begin
        hn_we++;
        if (h_ad !== 16'h5A5A) hn_bad++;
      end
      if (!h_ne) hn_ne++;
    end
  end

  task automatic send(input logic wr, input logic [15:0] a, input logic [1:0] be,
                      input logic [15:0] d, input logic [15:0] exp_rd,
                      input bit keep, input bit expect_out, output int acc_cyc);
    req_valid = 1; req_write = wr; req_addr = a; req_be = be; req_wdata = d;
    acc_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc_cyc < 0) check("accept_timeout", 0, 1);
    else if (expect_out) begin
      exp_bus.push_back('{wr, a, be, wr ? d : exp_rd});
      if (!wr) exp_rsp.push_back('{exp_rd, acc_cyc + 9});
    end
    @(negedge clk);
    if (!keep) req_valid = 0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, a4, a5, a6, b0, rc, n;
    int h_acc [2];
    int h_n;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h12] = 16'h1234;
    aclr = 0; req_valid = 0; req_write = 0; req_addr = 0; req_be = 0; req_wdata = 0; nirq = 1;
    h_valid = 0; h_write = 1; h_addr = 16'h0077; h_be = 2'b11; h_wdata = 16'h5A5A; h_nirq = 1;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {ne, noe, nwe, nadv, nbl}, 6'h3F);
    check("rst_ad_released", dut.r_ad_oe, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp", {rsp_valid, rsp_rdata}, 17'h0);
    check("rst_irq", irq, 0);
    aclr = 1;
    @(negedge clk);
    check("rel_ready", req_ready, 1);
    check("rel_strobes", {ne, noe, nwe, nadv, nbl}, 6'h3F);

    // Write then read, second request waiting during the first cycle
    send(1'b1, 16'h0040, 2'b11, 16'hA5C3, 16'h0, 1'b0, 1'b1, a1);
    send(1'b0, 16'h0012, 2'b11, 16'h0, 16'h1234, 1'b0, 1'b1, a2);
    check("accept_spacing_wr_rd", a2 - a1, 11);
    repeat (14) @(negedge clk);

    // Back-to-back with req_valid held; byte-lane write then readback
    b0 = bus_cnt;
    send(1'b1, 16'h0021, 2'b01, 16'hBEEF, 16'h0, 1'b1, 1'b1, a3);
    send(1'b0, 16'h0021, 2'b11, 16'h0, 16'h00EF, 1'b0, 1'b1, a4);
    check("accept_spacing_b2b", a4 - a3, 11);
    repeat (14) @(negedge clk);
    check("b2b_bus_cycles", bus_cnt - b0, 2);
    // TURN cycles plus the accepting IDLE cycle
    check("b2b_ne_gap", last_gap, 3);

    // Reset in the second DATA cycle of a read
    send(1'b0, 16'h0012, 2'b11, 16'h0, 16'h0, 1'b0, 1'b0, a5);
    while (cyc < a5 + 6) @(negedge clk);
    check("abort_in_data", noe, 0);
    rc = rsp_cnt;
    aclr = 0;
    @(negedge clk);
    check("abort_strobes", {ne, noe, nwe, nadv, nbl}, 6'h3F);
    check("abort_ad_released", dut.r_ad_oe, 0);
    @(posedge clk);
    #1 aclr = 1;
    repeat (8) @(negedge clk);
    check("abort_no_rsp", rsp_cnt - rc, 0);
    send(1'b0, 16'h0040, 2'b11, 16'h0, 16'hA5C3, 1'b0, 1'b1, a6);
    repeat (14) @(negedge clk);
    check("queues_drained", {32'(exp_bus.size()), 32'(exp_rsp.size())}, 64'h0);

    // Interrupt synchroniser
    #2 nirq = 0;
    n = 0;
    while (!irq && n < 10) begin @(negedge clk); n++; end
    check("irq_set_latency_ok", (n >= 2 && n <= 3), 1);
    #2 nirq = 1;
    n = 0;
    while (irq && n < 10) begin @(negedge clk); n++; end
    check("irq_clr_latency_ok", (n >= 2 && n <= 3), 1);

    // ADDHLD=0 instance: two writes with h_valid held
    @(negedge clk);
    h_valid = 1;
    h_n = 0;
    for (int i = 0; i < 40 && h_n < 2; i++) begin
      if (h_ready) begin
        h_acc[h_n] = cyc;
        h_n++;
        h_win = (h_n == 1);
      end
      @(negedge clk);
    end
    h_valid = 0;
    h_win = 0;
    if (h_n < 2) check("h_accept_timeout", h_n, 2);
    else check("h_accept_spacing", h_acc[1] - h_acc[0], 10);
    check("h_nadv_low", hn_adv, 3);
    check("h_ahold_skipped", hn_hold, 0);
    check("h_nwe_low", hn_we, 4);
    check("h_ne_low", hn_ne, 7);
    check("h_wdata", hn_bad, 0);
    repeat (12) @(negedge clk);

    check("ad_contention", contention, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
